// File: rtl/fetch_unit.sv
// fetch_unit: PC-owning instruction-fetch sequencer (REQ -> WAIT -> HOLD, sticky HALT on misaligned target)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc_in,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        inst_ready,
  output logic [31:0] pc_address,
  output logic        fetch_misaligned,
  output logic [31:0] inst_count
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, cnt_q, cnt_d;
  logic mis_q, mis_d;
  // next-state and registered-value updates; outputs are masked during reset
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    inst_d = inst_q;
    cnt_d = cnt_q;
    mis_d = mis_q;
    case (state_q)
      REQ:  state_d = imem_req_ready ? WAIT : REQ;
      WAIT: if (imem_resp_valid) begin
        inst_d = imem_resp_data;
        state_d = HOLD;
      end
      HOLD: if (inst_ready) begin
        cnt_d = cnt_q + 32'd1;
        inst_d = NOP_INST;
        pc_d = (next_pc_in[1:0] == 2'b00) ? next_pc_in : pc_q;
        mis_d = next_pc_in[1:0] != 2'b00;
        state_d = (next_pc_in[1:0] == 2'b00) ? REQ : HALT;
      end
      default: state_d = HALT;
    endcase
    imem_req_valid = !rst && state_q == REQ;
    inst_valid = !rst && state_q == HOLD;
  end
  assign imem_req_addr = pc_q;
  assign pc_address = pc_q;
  assign inst = inst_q;
  assign fetch_misaligned = mis_q;
  assign inst_count = cnt_q;
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      inst_q <= NOP_INST;
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inst_q <= inst_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst, imem_req_valid, imem_req_ready, imem_resp_valid, inst_valid, inst_ready, fetch_misaligned;
  logic [31:0] next_pc_in, imem_req_addr, imem_resp_data, inst, pc_address, inst_count;
  int n_chk = 0;
  int n_fail = 0;
  fetch_unit dut (
    .clk(clk), .rst(rst), .next_pc_in(next_pc_in),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .pc_address(pc_address), .fetch_misaligned(fetch_misaligned), .inst_count(inst_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] npc, input logic [31:0] data);
    chk("req_valid", 32'(imem_req_valid), 32'd1);
    chk("req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("wait_no_req", 32'(imem_req_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data = data;
    tick();
    imem_resp_valid = 1'b0;
    chk("hold_valid", 32'(inst_valid), 32'd1);
    chk("hold_inst", inst, data);
    chk("hold_pc", pc_address, addr);
    inst_ready = 1'b1;
    next_pc_in = npc;
    tick();
    inst_ready = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    next_pc_in = '0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    inst_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_pc", pc_address, 32'h0);
    chk("rst_inst", inst, NOP);
    chk("rst_count", inst_count, 32'h0);
    chk("rst_mis", 32'(fetch_misaligned), 32'd0);
    rst = 1'b0;
    #1;
    // stray response in REQ must be ignored
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    chk("req_drop_inst", inst, NOP);
    chk("req_drop_valid", 32'(inst_valid), 32'd0);
    fetch_one(32'h0, 32'h4, 32'h1111_0000);
    fetch_one(32'h4, 32'h8, 32'h1111_0004);
    fetch_one(32'h8, 32'hC, 32'h1111_0008);
    chk("seq_count", inst_count, 32'd3);
    chk("seq_pc", pc_address, 32'hC);
    chk("accept_inst_nop", inst, NOP);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
      chk("bp_req_addr", imem_req_addr, 32'hC);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h2222_000C;
    tick();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_inst_valid", 32'(inst_valid), 32'd1);
      chk("bp_inst", inst, 32'h2222_000C);
      chk("bp_pc", pc_address, 32'hC);
      chk("bp_count", inst_count, 32'd3);
    end
    inst_ready = 1'b1;
    next_pc_in = 32'h100;
    tick();
    inst_ready = 1'b0;
    fetch_one(32'h100, 32'h80, 32'h3333_0100);
    fetch_one(32'h80, 32'h102, 32'h3333_0080);
    chk("mis_flag", 32'(fetch_misaligned), 32'd1);
    chk("mis_pc", pc_address, 32'h80);
    chk("mis_count", inst_count, 32'd6);
    for (int i = 0; i < 3; i++) begin
      chk("halt_req", 32'(imem_req_valid), 32'd0);
      chk("halt_inst_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    chk("halt_pc", pc_address, 32'h80);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_mis", 32'(fetch_misaligned), 32'd0);
    chk("rst2_pc", pc_address, 32'h0);
    chk("rst2_req", 32'(imem_req_valid), 32'd1);
    fetch_one(32'h0, 32'h4, 32'h4444_0000);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h5555_0004;
    tick();
    rst = 1'b0;
    imem_resp_valid = 1'b0;
    chk("rstw_inst", inst, NOP);
    chk("rstw_count", inst_count, 32'h0);
    chk("rstw_pc", pc_address, 32'h0);
    #1;
    chk("rstw_inst_valid", 32'(inst_valid), 32'd0);
    fetch_one(32'h0, 32'hFFFF_FFFC, 32'h6666_0000);
    fetch_one(32'hFFFF_FFFC, 32'h0, 32'h6666_FFFC);
    chk("wrap_pc", pc_address, 32'h0);
    chk("wrap_req_addr", imem_req_addr, 32'h0);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    #1;
    chk("cnt_preload", inst_count, 32'hFFFF_FFFF);
    fetch_one(32'h0, 32'h4, 32'h7777_0000);
    chk("cnt_wrap", inst_count, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
